// File: rtl/conv_seq_ctrl_if.sv
// Memory-side bus of the convolution sequencer: X/Y synchronous read ports and Z write port.
interface conv_seq_ctrl_if #(
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned ADDRW     = 5,
   parameter int unsigned ZADDRW    = 6
);
   logic [ADDRW-1:0]     memx_addr;
   logic [DATAWIDTH-1:0] memx_rdata;
   logic [ADDRW-1:0]     memy_addr;
   logic [DATAWIDTH-1:0] memy_rdata;
   logic [ZADDRW-1:0]    memz_addr;
   logic [DATAWIDTH-1:0] memz_wdata;
   logic                 memz_we;

   // Sequencer side
   modport master (
      output memx_addr, memy_addr, memz_addr, memz_wdata, memz_we,
      input  memx_rdata, memy_rdata
   );

   // Memory side
   modport slave (
      input  memx_addr, memy_addr, memz_addr, memz_wdata, memz_we,
      output memx_rdata, memy_rdata
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 1-D convolution datapath: z[i] = sum_j x[j]*y[i-j].
// Walks every output index, issues X/Y reads, accumulates over the
// synchronous read data and writes each result to Z, then pulses done.
module conv_seq_ctrl #(
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned ADDRW     = 5,
   parameter int unsigned ZADDRW    = 6
) (
   input  logic              clk,
   input  logic              rst_a,
   input  logic              en_s,
   input  logic              start,
   input  logic [ADDRW-1:0]  size_x,
   input  logic [ADDRW-1:0]  size_y,
   conv_seq_ctrl_if.master   mem,
   output logic              busy,
   output logic              done
);
   localparam int unsigned PRODW = 2 * DATAWIDTH;
   localparam int unsigned ACCW  = 2 * DATAWIDTH + ADDRW;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]           state_q, state_d;
   logic [ADDRW-1:0]     sx_q, sx_d, sy_q, sy_d;
   logic [ZADDRW-1:0]    i_q, i_d;
   logic [ADDRW-1:0]     j_q, j_d;
   logic [ACCW-1:0]      acc_q, acc_d;
   logic                 rd_vld_q, rd_vld_d;
   logic [ADDRW-1:0]     memx_addr_d, memy_addr_d;
   logic [ZADDRW-1:0]    memz_addr_d;
   logic [DATAWIDTH-1:0] memz_wdata_d;
   logic                 memz_we_d, busy_d, done_d;

   logic [ZADDRW-1:0]    sx_w, sy_w, i_last, jhi_cur, i_inc, jlo_inc;
   logic [PRODW-1:0]     prod;
   logic                 empty;

   // Loop bounds for the current and next output index, and the MAC product
   always_comb begin
      sx_w    = ZADDRW'(sx_q);
      sy_w    = ZADDRW'(sy_q);
      empty   = (sx_q == '0) || (sy_q == '0);
      i_last  = sx_w + sy_w - ZADDRW'(2);
      jhi_cur = (i_q < sx_w) ? i_q : sx_w - ZADDRW'(1);
      i_inc   = i_q + ZADDRW'(1);
      jlo_inc = (i_inc >= sy_w) ? i_inc - sy_w + ZADDRW'(1) : '0;
      prod    = PRODW'(mem.memx_rdata) * PRODW'(mem.memy_rdata);
   end

   // Next-state, counter, accumulator and registered-output logic
   always_comb begin
      state_d      = state_q;
      sx_d         = sx_q;
      sy_d         = sy_q;
      i_d          = i_q;
      j_d          = j_q;
      acc_d        = acc_q;
      rd_vld_d     = rd_vld_q;
      memx_addr_d  = mem.memx_addr;
      memy_addr_d  = mem.memy_addr;
      memz_addr_d  = mem.memz_addr;
      memz_wdata_d = mem.memz_wdata;
      busy_d       = busy;
      memz_we_d    = 1'b0;
      done_d       = 1'b0;

      if (en_s) begin
         // Read data arrives one cycle after each FETCH
         rd_vld_d = 1'b0;
         if (rd_vld_q) acc_d = acc_q + ACCW'(prod);

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_INIT;
                  sx_d    = size_x;
                  sy_d    = size_y;
               end
            end
            S_INIT: begin
               i_d   = '0;
               j_d   = '0;
               acc_d = '0;
               // Empty runs spend one settling cycle in DRAIN before DONE
               if (empty) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d     = S_FETCH;
                  memx_addr_d = '0;
                  memy_addr_d = '0;
               end
            end
            S_FETCH: begin
               rd_vld_d = 1'b1;
               if (ZADDRW'(j_q) == jhi_cur) begin
                  state_d = S_DRAIN;
               end else begin
                  j_d         = j_q + ADDRW'(1);
                  memx_addr_d = j_q + ADDRW'(1);
                  memy_addr_d = ADDRW'(i_q - ZADDRW'(j_q) - ZADDRW'(1));
               end
            end
            S_DRAIN: begin
               state_d = empty ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
               if (i_q == i_last) begin
                  state_d = S_DONE;
               end else begin
                  state_d     = S_FETCH;
                  i_d         = i_inc;
                  acc_d       = '0;
                  j_d         = ADDRW'(jlo_inc);
                  memx_addr_d = ADDRW'(jlo_inc);
                  memy_addr_d = ADDRW'(i_inc - jlo_inc);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         // Registered outputs track the state being entered
         if (state_d == S_WRITE) begin
            memz_we_d    = 1'b1;
            memz_addr_d  = i_q;
            memz_wdata_d = acc_d[DATAWIDTH-1:0];
         end
         done_d = (state_d == S_DONE);
         busy_d = (state_d != S_IDLE);
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state_q        <= S_IDLE;
         sx_q           <= '0;
         sy_q           <= '0;
         i_q            <= '0;
         j_q            <= '0;
         acc_q          <= '0;
         rd_vld_q       <= 1'b0;
         mem.memx_addr  <= '0;
         mem.memy_addr  <= '0;
         mem.memz_addr  <= '0;
         mem.memz_wdata <= '0;
         mem.memz_we    <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state_q        <= state_d;
         sx_q           <= sx_d;
         sy_q           <= sy_d;
         i_q            <= i_d;
         j_q            <= j_d;
         acc_q          <= acc_d;
         rd_vld_q       <= rd_vld_d;
         mem.memx_addr  <= memx_addr_d;
         mem.memy_addr  <= memy_addr_d;
         mem.memz_addr  <= memz_addr_d;
         mem.memz_wdata <= memz_wdata_d;
         mem.memz_we    <= memz_we_d;
         busy           <= busy_d;
         done           <= done_d;
      end
   end
endmodule
